// File: rtl/fp_dsqa_pkg.sv
// Shared constants, state encoding and operand unpacking for the dsqa/xfsq unit.
package fp_dsqa_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SUB,
    S_NORM,
    S_MUL,
    S_PACK
  } state_e;

  localparam logic [2:0]  F3_XFSQ    = 3'b001;
  localparam logic [2:0]  F3_DSQA    = 3'b010;
  localparam int unsigned BIAS       = 127;
  localparam logic [31:0] QNAN       = 32'h7FC0_0000;
  localparam logic [31:0] PINF       = 32'h7F80_0000;
  localparam int unsigned MUL_CYCLES = 24;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 24;
  localparam int unsigned GRD_W  = MANT_W + 3;
  localparam int unsigned SUM_W  = GRD_W + 1;
  localparam int unsigned PROD_W = 2 * MANT_W;
  localparam int unsigned CNT_W  = 5;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } fp_unp_t;

  // Exponent 0 flushes to a zero mantissa (no denormal support).
  function automatic fp_unp_t fp_unpack(input logic [31:0] x);
    fp_unp_t u;
    u.sign = x[31];
    u.exp  = x[30:23];
    u.mant = (x[30:23] == 8'd0) ? '0 : {1'b1, x[22:0]};
    return u;
  endfunction

endpackage

// File: rtl/fp_dsqa_unit_mul.sv
// Iterative radix-2 shift-add 24x24 multiplier; one partial product per cycle.
module mant_mul24
  import fp_dsqa_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [MANT_W-1:0] a_i,
  input  logic [MANT_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_c,
  output logic [MANT_W:0]   prod_hi_o
);

  logic [PROD_W-1:0] acc_q, acc_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  // done_c is high during the cycle in which the last partial product is added.
  assign done_c    = busy_q && (cnt_q == CNT_W'(MUL_CYCLES - 1));
  assign busy_o    = busy_q;
  assign prod_hi_o = acc_q[PROD_W-1:MANT_W-1];

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = {{MANT_W{1'b0}}, a_i};
      mplier_d = b_i;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (done_c) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/fp_dsqa_unit.sv
// Multicycle float32 (rs1-rs2)^2 unit, fixed 29-cycle latency, truncating.
// Define XFSQ_EN to also accept funct3=001 (xfsq: rs1^2).
module fp_dsqa_unit
  import fp_dsqa_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [31:0] rd_data
);

  state_e            state_q, state_d;
  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              xfsq_q, xfsq_d;
  logic              nan_q, nan_d;
  logic [GRD_W-1:0]  big_q, big_d, small_q, small_d;
  logic              sub_q, sub_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic signed [9:0] nexp_q, nexp_d;
  logic              zero_q, zero_d;
  logic              done_q, done_d;
  logic              illegal_q, illegal_d;
  logic [31:0]       rd_q, rd_d;

  logic              f3_legal, f3_xfsq;
  logic              mul_load, mul_busy, mul_done;
  logic [MANT_W:0]   prod_hi;

  always_comb begin
    f3_legal = (funct3 == F3_DSQA);
    f3_xfsq  = 1'b0;
`ifdef XFSQ_EN
    if (funct3 == F3_XFSQ) begin
      f3_legal = 1'b1;
      f3_xfsq  = 1'b1;
    end
`endif
  end

  // ALIGN: order magnitudes, shift the smaller one into place with 3 guard bits.
  fp_unp_t          ua, ub;
  logic             a_ge;
  logic [MANT_W-1:0] big_m, sml_m;
  logic [EXP_W-1:0] big_e, sml_e, exp_diff;
  logic [GRD_W-1:0] aln_big, aln_small;
  logic [EXP_W-1:0] aln_e;
  logic             aln_sub, aln_nan;

  always_comb begin
    ua       = fp_unpack(a_q);
    ub       = fp_unpack(b_q);
    a_ge     = {ua.exp, ua.mant} >= {ub.exp, ub.mant};
    big_m    = a_ge ? ua.mant : ub.mant;
    sml_m    = a_ge ? ub.mant : ua.mant;
    big_e    = a_ge ? ua.exp  : ub.exp;
    sml_e    = a_ge ? ub.exp  : ua.exp;
    exp_diff = big_e - sml_e;
    aln_big  = {big_m, 3'b000};
    aln_small = (exp_diff >= 8'd26) ? '0 : ({sml_m, 3'b000} >> exp_diff);
    aln_e    = big_e;
    aln_sub  = (ua.sign == ub.sign);
    aln_nan  = (ua.exp == 8'hFF) || (ub.exp == 8'hFF);
    if (xfsq_q) begin
      aln_big   = {ua.mant, 3'b000};
      aln_small = '0;
      aln_e     = ua.exp;
      aln_sub   = 1'b0;
      aln_nan   = (ua.exp == 8'hFF);
    end
  end

  // SUB: big >= small, so the subtract never goes negative.
  logic [SUM_W-1:0] sub_sum;
  assign sub_sum = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                         : ({1'b0, big_q} + {1'b0, small_q});

  // NORM: leading-one detect, left-justify, keep the top 24 bits.
  logic [4:0]        lead_pos;
  logic [SUM_W-1:0]  norm_sh;
  logic [MANT_W-1:0] norm_mant;
  logic signed [9:0] norm_exp;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (sum_q[i]) begin
        lead_pos = 5'(i);
      end
    end
    norm_sh   = sum_q << (5'd27 - lead_pos);
    norm_mant = MANT_W'(norm_sh >> 4);
    norm_exp  = $signed(10'(exp_q)) + $signed(10'(lead_pos)) - 10'sd26;
  end

  mant_mul24 u_mul (
    .clk       (clk),
    .reset     (reset),
    .load_i    (mul_load),
    .a_i       (norm_mant),
    .b_i       (norm_mant),
    .busy_o    (mul_busy),
    .done_c    (mul_done),
    .prod_hi_o (prod_hi)
  );

  // PACK: squared exponent, truncated fraction, special-case overrides.
  logic               prod_top;
  logic [22:0]        pack_frac;
  logic signed [11:0] pack_exp;
  logic [31:0]        pack_res;

  always_comb begin
    prod_top  = prod_hi[MANT_W];
    pack_frac = prod_top ? prod_hi[23:1] : prod_hi[22:0];
    pack_exp  = $signed({nexp_q[9], nexp_q, 1'b0}) - 12'sd127
              + $signed({11'd0, prod_top});
    if (nan_q) begin
      pack_res = QNAN;
    end else if (zero_q || (pack_exp <= 12'sd0)) begin
      pack_res = 32'h0000_0000;
    end else if (pack_exp >= 12'sd255) begin
      pack_res = PINF;
    end else begin
      pack_res = {1'b0, pack_exp[7:0], pack_frac};
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    xfsq_d    = xfsq_q;
    nan_d     = nan_q;
    big_d     = big_q;
    small_d   = small_q;
    sub_d     = sub_q;
    exp_d     = exp_q;
    sum_d     = sum_q;
    nexp_d    = nexp_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    rd_d      = rd_q;
    mul_load  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (f3_legal) begin
            state_d = S_ALIGN;
            a_d     = rs1;
            b_d     = rs2;
            xfsq_d  = f3_xfsq;
          end else begin
            done_d    = 1'b1;
            illegal_d = 1'b1;
            rd_d      = '0;
          end
        end
      end
      S_ALIGN: begin
        big_d   = aln_big;
        small_d = aln_small;
        exp_d   = aln_e;
        sub_d   = aln_sub;
        nan_d   = aln_nan;
        state_d = S_SUB;
      end
      S_SUB: begin
        sum_d   = sub_sum;
        state_d = S_NORM;
      end
      S_NORM: begin
        nexp_d   = norm_exp;
        zero_d   = (sum_q == '0);
        mul_load = 1'b1;
        state_d  = S_MUL;
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_PACK;
        end
      end
      S_PACK: begin
        rd_d    = pack_res;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      xfsq_q    <= 1'b0;
      nan_q     <= 1'b0;
      big_q     <= '0;
      small_q   <= '0;
      sub_q     <= 1'b0;
      exp_q     <= '0;
      sum_q     <= '0;
      nexp_q    <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      rd_q      <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      xfsq_q    <= xfsq_d;
      nan_q     <= nan_d;
      big_q     <= big_d;
      small_q   <= small_d;
      sub_q     <= sub_d;
      exp_q     <= exp_d;
      sum_q     <= sum_d;
      nexp_q    <= nexp_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      rd_q      <= rd_d;
    end
  end

  // busy tracks the state register; mul_busy is implied by state MUL.
  logic unused_mul_busy;
  assign unused_mul_busy = mul_busy;

  assign busy    = (state_q != S_IDLE) || (unused_mul_busy && 1'b0);
  assign done    = done_q;
  assign illegal = illegal_q;
  assign rd_data = rd_q;

endmodule

// File: tb/tb_fp_dsqa_unit.sv
// Self-checking bench for fp_dsqa_unit: vector table, scoreboard, corner sequences.
module tb_fp_dsqa_unit;
  import fp_dsqa_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done, illegal;
  logic [31:0] rd_data;

  fp_dsqa_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .rs1     (rs1),
    .rs2     (rs2),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    logic        ill;
    int          due;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int done_seen = 0;
  int last_done = 0;
  int prev_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Truncating reference: align, add/sub, normalize to 1.x, square with 64-bit math.
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input bit xf);
    int ea, eb, eg, es, d, en, ex;
    longint ma, mb, big, sml, s, p;
    logic [63:0] pv;
    logic [22:0] frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if (ea == 255 || (!xf && eb == 255)) return QNAN;
    ma = (ea == 0) ? 64'sd0 : (longint'({1'b1, a[22:0]}) <<< 3);
    mb = (eb == 0) ? 64'sd0 : (longint'({1'b1, b[22:0]}) <<< 3);
    if (xf) begin
      eg = ea;
      s  = ma;
    end else begin
      if (ea > eb || (ea == eb && ma >= mb)) begin
        big = ma; eg = ea; sml = mb; es = eb;
      end else begin
        big = mb; eg = eb; sml = ma; es = ea;
      end
      d   = eg - es;
      sml = (d >= 26) ? 64'sd0 : (sml >>> d);
      s   = (a[31] == b[31]) ? (big - sml) : (big + sml);
    end
    if (s == 0) return 32'h0;
    en = eg;
    while (s >= (64'sd1 <<< 27)) begin s = s >>> 1; en++; end
    while (s < (64'sd1 <<< 26)) begin s = s <<< 1; en--; end
    p  = (s >>> 3) * (s >>> 3);
    pv = p;
    if (pv[47]) begin
      ex = 2 * en - int'(BIAS) + 1;
      frac = pv[46:24];
    end else begin
      ex = 2 * en - int'(BIAS);
      frac = pv[45:23];
    end
    if (ex >= 255) return PINF;
    if (ex <= 0) return 32'h0;
    return {1'b0, 8'(ex), frac};
  endfunction

  // Scoreboard monitor: every done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && done) begin
      done_seen++;
      prev_done = last_done;
      last_done = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("rd_data", rd_data, mon_e.rd);
        chk("illegal", {31'd0, illegal}, {31'd0, mon_e.ill});
        chk("latency", cyc, mon_e.due);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] erd, input logic eill);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("issue_timeout", {31'd0, busy}, 32'd0);
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    e.rd   = erd;
    e.ill  = eill;
    e.due  = eill ? cyc : cyc + 28;
    sbq.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sbq.size(), 0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
    logic        ill;
  } vec_t;
  vec_t vt[15];

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, k;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; rs1 = '0; rs2 = '0;

    vt[0]  = '{3'b010, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0};
    vt[1]  = '{3'b010, 32'h420A_3D71, 32'h420A_3D71, 32'h0000_0000, 1'b0};
    vt[2]  = '{3'b010, 32'hBFC0_0000, 32'h3FC0_0000, 32'h4110_0000, 1'b0};
    vt[3]  = '{3'b010, 32'h7F00_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0};
    vt[4]  = '{3'b010, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0};
    vt[5]  = '{3'b111, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1};
`ifdef XFSQ_EN
    vt[6]  = '{3'b001, 32'h4040_0000, 32'h0000_0000, 32'h4110_0000, 1'b0};
`else
    vt[6]  = '{3'b001, 32'h4040_0000, 32'h0000_0000, 32'h0000_0000, 1'b1};
`endif
    vt[7]  = '{3'b010, 32'h3F80_0000, 32'h4040_0000, 32'h4080_0000, 1'b0};
    vt[8]  = '{3'b010, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0};
    vt[9]  = '{3'b010, 32'h7F80_0000, 32'h3F80_0000, 32'h7FC0_0000, 1'b0};
    vt[10] = '{3'b000, 32'h4040_0000, 32'h3F80_0000, 32'h0000_0000, 1'b1};
    vt[11] = '{3'b010, 32'h1F80_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[12] = '{3'b010, 32'h2000_0000, 32'h0000_0000, 32'h0080_0000, 1'b0};
    vt[13] = '{3'b010, 32'h5F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0};
    vt[14] = '{3'b010, 32'h5F00_0000, 32'h0000_0000, 32'h7E80_0000, 1'b0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);

    foreach (vt[i]) issue(vt[i].f3, vt[i].a, vt[i].b, vt[i].rd, vt[i].ill);
    drain();

    // Starts while busy (legal and illegal) must be dropped.
    issue(3'b010, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0);
    repeat (5) @(negedge clk);
    chk("busy_mid", {31'd0, busy}, 32'd1);
    funct3 = 3'b010; rs1 = 32'h7F80_0000; rs2 = 32'h0; start = 1'b1;
    @(negedge clk);
    funct3 = 3'b111;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (35) @(negedge clk);

    // Reset mid-operation aborts without a done pulse.
    issue(3'b010, 32'hBFC0_0000, 32'h3FC0_0000, 32'h4110_0000, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    sbq.delete();
    d0 = done_seen;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    repeat (30) @(negedge clk);
    chk("abort_no_done", done_seen - d0, 0);
    issue(3'b010, 32'hBFC0_0000, 32'h3FC0_0000, 32'h4110_0000, 1'b0);
    drain();

    // Back-to-back: second start lands in the first request's done cycle.
    issue(3'b010, 32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0);
    issue(3'b010, 32'h7F00_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0);
    drain();
    chk("b2b_gap", last_done - prev_done, 29);

    // Randomized operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 160)), 23'($urandom)};
      k = int'($urandom_range(0, 4));
      case (k)
        0: b = {1'($urandom_range(0, 1)), 8'($urandom_range(90, 160)), 23'($urandom)};
        1: b = a ^ {9'd0, 23'($urandom_range(0, 255))};
        2: b = {~a[31], a[30:23] + 8'($urandom_range(0, 2)), 23'($urandom)};
        3: b = {1'b0, (($urandom_range(0, 1) == 0) ? 8'd0 : 8'hFF), 23'($urandom)};
        default: b = {a[31], a[30:23] - 8'($urandom_range(20, 30)), 23'($urandom)};
      endcase
      issue(3'b010, a, b, ref_model(a, b, 1'b0), 1'b0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
